// File: rtl/mouse_receiver.sv
// mouse_receiver: PS/2 device-to-host frame receiver.
// Deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop) and
// presents each byte with a 2-bit error code and a one-cycle BYTE_READY pulse.
// Optional build macro MOUSE_RX_TIMEOUT_EN adds an inter-edge timeout that
// returns the FSM to IDLE when the PS/2 clock stalls mid-frame.
//
// Handshake: BYTE_READY is a valid-only strobe with no back-pressure; it is
// high for exactly one CLK cycle and BYTE_READ/BYTE_ERROR_CODE are stable from
// that cycle until the next strobe. Errored bytes are still strobed.
module mouse_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0] clk_dly_q, clk_dly_d;
  logic [2:0] data_dly_q, data_dly_d;
  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic [7:0] byte_read_q, byte_read_d;
  logic [1:0] err_q, err_d;
  logic       ready_q, ready_d;

  logic fe;
  logic bit_s;
  logic tmo_hit;
  logic unused_data_msb;

  // Falling edge of the synchronised PS/2 clock and the data bit sampled with it.
  assign fe              = clk_dly_q[2] & ~clk_dly_q[1];
  assign bit_s           = data_dly_q[1];
  assign unused_data_msb = data_dly_q[2];

  // Shift both asynchronous lines into three-stage synchroniser chains.
  always_comb begin
    clk_dly_d  = {clk_dly_q[1:0], CLK_MOUSE_IN};
    data_dly_d = {data_dly_q[1:0], DATA_MOUSE_IN};
  end

`ifdef MOUSE_RX_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q, tmo_d;
  logic        in_frame;

  // Count idle CLK cycles between PS/2 falling edges while inside a frame;
  // an edge in the same cycle as the limit wins over the timeout.
  always_comb begin
    tmo_d    = '0;
    tmo_hit  = 1'b0;
    in_frame = (state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP);
    if (in_frame && !fe) begin
      if (tmo_q == TMO_LIMIT) begin
        tmo_hit = 1'b1;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end
  end

  // Timeout counter register.
  always_ff @(posedge CLK) begin
    if (RESET) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign tmo_hit        = 1'b0;
`endif

  // Frame FSM: start detection, data shift, parity/stop capture, output strobe.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    byte_read_d = byte_read_q;
    err_d       = err_q;
    ready_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A high start bit is a glitch; READ_ENABLE low leaves the bus to the transmitter.
        if (fe && READ_ENABLE && !bit_s) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (fe) begin
          shift_d   = {bit_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      S_PARITY: begin
        if (fe) begin
          parity_d = bit_s;
          state_d  = S_STOP;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      S_STOP: begin
        // Outputs are registered here so they appear together with the DONE cycle.
        if (fe) begin
          byte_read_d = shift_q;
          err_d       = {~bit_s, ~^{shift_q, parity_q}};
          ready_d     = 1'b1;
          state_d     = S_DONE;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      clk_dly_q   <= 3'b111;
      data_dly_q  <= 3'b111;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      byte_read_q <= 8'h00;
      err_q       <= 2'b00;
      ready_q     <= 1'b0;
    end else begin
      clk_dly_q   <= clk_dly_d;
      data_dly_q  <= data_dly_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      byte_read_q <= byte_read_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
    end
  end

  assign BYTE_READ       = byte_read_q;
  assign BYTE_ERROR_CODE = err_q;
  assign BYTE_READY      = ready_q;

endmodule

// File: tb/tb_mouse_receiver.sv
// tb_mouse_receiver: directed bench for mouse_receiver.
// The PS/2 bit period is shortened to 80 CLK cycles and TIMEOUT_CYCLES to 300
// so every scenario, including the stall, fits in a short run.
module tb_mouse_receiver;

  logic       clk;
  logic       reset;
  logic       clk_mouse_in;
  logic       data_mouse_in;
  logic       read_enable;
  logic [7:0] byte_read;
  logic [1:0] byte_error_code;
  logic       byte_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_cnt = 0;
  int ready_cyc = 0;
  int fall_cyc = 0;
  int cnt_before;

  mouse_receiver #(.TIMEOUT_CYCLES(300)) dut (
    .CLK             (clk),
    .RESET           (reset),
    .CLK_MOUSE_IN    (clk_mouse_in),
    .DATA_MOUSE_IN   (data_mouse_in),
    .READ_ENABLE     (read_enable),
    .BYTE_READ       (byte_read),
    .BYTE_ERROR_CODE (byte_error_code),
    .BYTE_READY      (byte_ready)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Count every cycle BYTE_READY is high; a stretched pulse counts twice.
  always @(negedge clk) begin
    if (byte_ready) begin
      ready_cnt = ready_cnt + 1;
      ready_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device-side bit: data changes while the PS/2 clock is high.
  task automatic send_bit(input logic b);
    @(negedge clk);
    data_mouse_in = b;
    wait_cycles(20);
    clk_mouse_in = 1'b0;
    fall_cyc = cyc;
    wait_cycles(40);
    clk_mouse_in = 1'b1;
    wait_cycles(20);
  endtask

  // Send the first nbits of {stop, parity, data, start}.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int nbits);
    logic [10:0] f;
    f = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    data_mouse_in = 1'b1;
    wait_cycles(40);
  endtask

  initial begin
    reset         = 1'b1;
    clk_mouse_in  = 1'b1;
    data_mouse_in = 1'b1;
    read_enable   = 1'b1;
    wait_cycles(5);
    check("reset_byte", {24'd0, byte_read}, 32'h00);
    check("reset_code", {30'd0, byte_error_code}, 32'h0);
    check("reset_ready", {31'd0, byte_ready}, 32'h0);
    check("reset_state", {29'd0, dut.state_q}, 32'h0);
    reset = 1'b0;
    wait_cycles(10);

    // 0xFA, odd parity 1, stop 1: clean byte, strobe 3 cycles after the stop-bit fall.
    cnt_before = ready_cnt;
    send_frame(8'hFA, 1'b1, 1'b1, 11);
    check("fa_pulses", ready_cnt - cnt_before, 32'd1);
    check("fa_byte", {24'd0, byte_read}, 32'hFA);
    check("fa_code", {30'd0, byte_error_code}, 32'h0);
    check("fa_latency", ready_cyc - fall_cyc, 32'd3);

    // 0x08 with parity 1: two ones in total, parity error.
    cnt_before = ready_cnt;
    send_frame(8'h08, 1'b1, 1'b1, 11);
    check("p_err_pulses", ready_cnt - cnt_before, 32'd1);
    check("p_err_byte", {24'd0, byte_read}, 32'h08);
    check("p_err_code", {30'd0, byte_error_code}, 32'h1);

    // 0x00 with parity 1 and stop 0: stop-bit error only.
    cnt_before = ready_cnt;
    send_frame(8'h00, 1'b1, 1'b0, 11);
    check("s_err_pulses", ready_cnt - cnt_before, 32'd1);
    check("s_err_byte", {24'd0, byte_read}, 32'h00);
    check("s_err_code", {30'd0, byte_error_code}, 32'h2);
    wait_cycles(100);

    // 0xAA with READ_ENABLE low: ignored, previous byte and code held.
    read_enable = 1'b0;
    cnt_before = ready_cnt;
    send_frame(8'hAA, 1'b1, 1'b1, 11);
    check("dis_pulses", ready_cnt - cnt_before, 32'd0);
    check("dis_byte", {24'd0, byte_read}, 32'h00);
    check("dis_code", {30'd0, byte_error_code}, 32'h2);

    // Same frame enabled.
    read_enable = 1'b1;
    cnt_before = ready_cnt;
    send_frame(8'hAA, 1'b1, 1'b1, 11);
    check("en_pulses", ready_cnt - cnt_before, 32'd1);
    check("en_byte", {24'd0, byte_read}, 32'hAA);
    check("en_code", {30'd0, byte_error_code}, 32'h0);

    // Reset after start + 4 data bits, then a clean 0x55.
    cnt_before = ready_cnt;
    send_frame(8'h33, 1'b1, 1'b1, 5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_byte", {24'd0, byte_read}, 32'h00);
    check("rst_code", {30'd0, byte_error_code}, 32'h0);
    check("rst_state", {29'd0, dut.state_q}, 32'h0);
    wait_cycles(100);
    check("rst_pulses", ready_cnt - cnt_before, 32'd0);
    send_frame(8'h55, 1'b1, 1'b1, 11);
    check("post_rst_pulses", ready_cnt - cnt_before, 32'd1);
    check("post_rst_byte", {24'd0, byte_read}, 32'h55);
    check("post_rst_code", {30'd0, byte_error_code}, 32'h0);
    wait_cycles(100);

    // Stall after start + 3 data bits, then a full 0x3C frame.
    cnt_before = ready_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 4);
    wait_cycles(600);
    check("stall_pulses", ready_cnt - cnt_before, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b1, 11);
    check("tmo_pulses", ready_cnt - cnt_before, 32'd1);
`ifdef MOUSE_RX_TIMEOUT_EN
    check("tmo_byte", {24'd0, byte_read}, 32'h3C);
    check("tmo_code", {30'd0, byte_error_code}, 32'h0);
`else
    // Bits 0,0,1 then 0,0,0,1,1 of the new frame form 0xC4; parity 1 makes four ones.
    check("no_tmo_byte", {24'd0, byte_read}, 32'hC4);
    check("no_tmo_code", {30'd0, byte_error_code}, 32'h1);
    check("no_tmo_not_3c", {31'd0, (byte_read != 8'h3C)}, 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
